// File: rtl/fifo_ram_1w1r.sv
// rtl/fifo_ram_1w1r.sv - simple dual-port RAM, synchronous write and registered read
module fifo_ram_1w1r #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO over a 1W1R RAM
module sync_fifo_fwft #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             pf_valid_q, pf_valid_d;
    logic             pf_src_in_q, pf_src_in_d;
    logic [WIDTH-1:0] pf_byp_q, pf_byp_d;
    logic             overflow_q, overflow_d;

    logic             in_ready_w;
    logic             push, pop;
    logic [CNT_W-1:0] ram_cnt;
    logic             ram_empty;
    logic             out_free, pf_to_out, pf_free;
    logic             push_to_out, push_to_pf;
    logic             ram_we, ram_re;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] pf_data;

    // The prefetch slot is either the RAM read register or a bypass holding register.
    assign pf_data = pf_src_in_q ? pf_byp_q : ram_rdata;

    always_comb begin
        in_ready_w  = (count_q < CNT_W'(DEPTH));
        push        = in_valid && in_ready_w && !flush;
        pop         = out_valid_q && out_ready;
        ram_cnt     = count_q - CNT_W'(out_valid_q) - CNT_W'(pf_valid_q);
        ram_empty   = (ram_cnt == '0);
        out_free    = !out_valid_q || pop;
        pf_to_out   = pf_valid_q && out_free;
        pf_free     = !pf_valid_q || pf_to_out;
        // Incoming data skips the RAM only when nothing older is stored there.
        push_to_out = push && out_free && !pf_valid_q && ram_empty;
        push_to_pf  = push && !push_to_out && pf_free && ram_empty;
        ram_we      = push && !push_to_out && !push_to_pf;
        ram_re      = pf_free && !ram_empty;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pf_valid_d  = pf_valid_q;
        pf_src_in_d = pf_src_in_q;
        pf_byp_d    = pf_byp_q;
        overflow_d  = overflow_q | (in_valid && !in_ready_w);

        if (pf_to_out) begin
            out_valid_d = 1'b1;
            out_data_d  = pf_data;
        end else if (push_to_out) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (ram_re) begin
            pf_valid_d  = 1'b1;
            pf_src_in_d = 1'b0;
        end else if (push_to_pf) begin
            pf_valid_d  = 1'b1;
            pf_src_in_d = 1'b1;
            pf_byp_d    = in_data;
        end else if (pf_to_out) begin
            pf_valid_d  = 1'b0;
        end

        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (ram_re) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A read launched in the flush cycle is dropped by clearing pf_valid.
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            pf_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pf_valid_q  <= 1'b0;
            pf_src_in_q <= 1'b0;
            pf_byp_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pf_valid_q  <= pf_valid_d;
            pf_src_in_q <= pf_src_in_d;
            pf_byp_q    <= pf_byp_d;
            overflow_q  <= overflow_d;
        end
    end

    fifo_ram_1w1r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_en_i   (ram_re),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rdata)
    );

    assign in_ready     = in_ready_w;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign overflow     = overflow_q;

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Parametrised synchronous FIFO with first-word-fall-through (FWFT) output and valid/ready handshakes on both sides.
- Successor to the team's single-purpose RAM/register primitives: a general buffering block for bus adapters and peripheral data paths (SDRAM controller request/response queues, UART).
- Bulk storage is a synchronous-read 1W1R RAM. A small prefetch/output stage hides the read latency, so the FIFO sustains one push and one pop per cycle.

Parameters:
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 16, total capacity in entries; power of two, >=4
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents; same effect as rst on FIFO state
- in_valid  in  1  producer has data
- in_ready  out  1  FIFO can accept; equals (count < DEPTH)
- in_data  in  WIDTH  write data
- out_valid  out  1  out_data holds the oldest entry
- out_ready  in  1  consumer accepts out_data
- out_data  out  WIDTH  oldest entry; registered
- count  out  $clog2(DEPTH+1)  entries held, 0..DEPTH
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- overflow  out  1  sticky; set when in_valid && !in_ready; cleared only by rst

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, out_valid=0, out_data=0, overflow=0, pointers=0.
  - in_ready=1, almost_empty=1, almost_full=(AF_THRESH==0).
  - RAM contents are not cleared.
- Handshakes:
  - push = in_valid && in_ready; pop = out_valid && out_ready, both sampled at the rising edge.
  - in_valid while !in_ready is refused: data is dropped, overflow is set.
  - out_data is stable while out_valid && !out_ready.
- count update: count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- in_ready, almost_full and almost_empty are combinational from registered count only. They never depend on out_ready, so the input and output paths stay decoupled.
- Full (count==DEPTH): in_ready=0. A pop in the same cycle does not allow a push that cycle; in_ready rises the next cycle.
- Empty (count==0):
  - out_valid=0.
  - A push at edge E gives out_valid=1 and out_data=in_data right after E (one-cycle fall-through via a bypass into the output register).
  - A pop cannot occur while empty.
- Latency and throughput:
  - With count>=1 and out_ready held high, one entry is delivered per cycle with no bubbles, including back-to-back push/pop at count==1.
  - Output stage = output register plus one prefetch register fed by the RAM synchronous read.
  - The RAM read is issued when the prefetch slot will be empty or consumed next cycle.
  - Entries in the output stage are included in count. RAM occupancy never exceeds DEPTH.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. No separate full/empty bit is kept; count is the single source of truth.
- Ordering: strict FIFO. Data pushed while the RAM is empty and the output stage is partially full must still exit in push order. The bypass path is used only when RAM and prefetch are both empty.
- flush:
  - Clears count, pointers and out_valid at the edge; overflow is kept.
  - A push in the flush cycle is discarded.
  - Asserting flush mid-stream with pending RAM reads must not leave stale data in the output stage.
- rst mid-operation: same as the reset state, regardless of in-flight reads.
- RAM read-during-write to the same address never occurs; the bypass covers that case.

Decomposition:
- No shared package needed. Derived localparams (PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)) stay local.
- One sub-module: fifo_ram_1w1r.
  - Parameters WIDTH and DEPTH.
  - Synchronous write; synchronous read with read-enable and registered read data.
  - Separate read and write addresses.
  - Contents are not reset.

Test Plan:
- Reset then idle: count=0, out_valid=0, in_ready=1, almost_empty=1, overflow=0.
- Push 0xA5 into empty FIFO at edge E: out_valid=1, out_data=0xA5 after E. Pop at E+1: count=0, out_valid=0.
- Fill DEPTH=16 with 0..15 (out_ready=0):
  - After 16 pushes: in_ready=0, almost_full=1 from count=14.
  - A 17th in_valid sets overflow=1; count stays 16.
  - Draining returns 0..15 in order.
- Streaming: in_valid=out_ready=1 for 100 cycles with incrementing data from count=0. After the first cycle, one pop per cycle, no gaps, data in order; count stays at 1.
- Full with simultaneous push+pop at count=16: pop succeeds, push refused (in_ready=0). Count=15, then in_ready=1 on the next cycle.
- flush at count=9 with a RAM read pending:
  - Next cycle count=0, out_valid=0, overflow is unchanged.
  - The subsequent push of 0x3C appears first at out_data.
